// File: rtl/ex_wb_ctrl_pipe.sv
// EX/MEM and MEM/WB control pipeline with EX-stage forwarding selects
// and load-use stall detection for the ID stage.
module ex_wb_ctrl_pipe #(
  parameter int REG_ADDR_W = 4,
  parameter int PC_REG     = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  flush_ex,
  input  logic                  ex_reg_write_enable,
  input  logic                  ex_mem_write_enable,
  input  logic                  ex_mem_to_reg_select,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] ex_rs_a,
  input  logic [REG_ADDR_W-1:0] ex_rs_b,
  input  logic [REG_ADDR_W-1:0] id_rs_a,
  input  logic [REG_ADDR_W-1:0] id_rs_b,
  input  logic                  id_rs_b_used,
  output logic                  mem_reg_write_enable,
  output logic                  mem_mem_write_enable,
  output logic                  mem_mem_to_reg_select,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_reg_write_enable,
  output logic                  wb_mem_to_reg_select,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            fwd_a_select,
  output logic [1:0]            fwd_b_select,
  output logic                  load_use_stall
);

  localparam logic [REG_ADDR_W-1:0] PC_IDX = REG_ADDR_W'(PC_REG);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_reg_write_enable  <= 1'b0;
      mem_mem_write_enable  <= 1'b0;
      mem_mem_to_reg_select <= 1'b0;
      mem_rd                <= '0;
      wb_reg_write_enable   <= 1'b0;
      wb_mem_to_reg_select  <= 1'b0;
      wb_rd                 <= '0;
    end else if (!hold) begin
      if (flush_ex) begin
        mem_reg_write_enable  <= 1'b0;
        mem_mem_write_enable  <= 1'b0;
        mem_mem_to_reg_select <= 1'b0;
        mem_rd                <= '0;
      end else begin
        mem_reg_write_enable  <= ex_reg_write_enable;
        mem_mem_write_enable  <= ex_mem_write_enable;
        mem_mem_to_reg_select <= ex_mem_to_reg_select;
        mem_rd                <= ex_rd;
      end
      wb_reg_write_enable  <= mem_reg_write_enable;
      wb_mem_to_reg_select <= mem_mem_to_reg_select;
      wb_rd                <= mem_rd;
    end
  end

  // A load in MEM has no data yet, so only ALU results forward from EX/MEM.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                         input logic mem_we, input logic mem_ld,
                                         input logic [REG_ADDR_W-1:0] m_rd,
                                         input logic wb_we,
                                         input logic [REG_ADDR_W-1:0] w_rd);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != PC_IDX) begin
      if (mem_we && !mem_ld && (m_rd == rs))
        sel = 2'b10;
      else if (wb_we && (w_rd == rs))
        sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a_select = fwd_sel(ex_rs_a, mem_reg_write_enable, mem_mem_to_reg_select,
                           mem_rd, wb_reg_write_enable, wb_rd);
    fwd_b_select = fwd_sel(ex_rs_b, mem_reg_write_enable, mem_mem_to_reg_select,
                           mem_rd, wb_reg_write_enable, wb_rd);
  end

  always_comb begin
    load_use_stall = ex_reg_write_enable && ex_mem_to_reg_select && (ex_rd != PC_IDX) &&
                     ((ex_rd == id_rs_a) || (id_rs_b_used && (ex_rd == id_rs_b))) &&
                     !flush_ex && !reset;
  end

endmodule

// File: tb/tb_ex_wb_ctrl_pipe.sv
// Scoreboard bench for ex_wb_ctrl_pipe: directed vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_ex_wb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       reset, hold, flush_ex;
  logic       ex_reg_write_enable, ex_mem_write_enable, ex_mem_to_reg_select;
  logic [3:0] ex_rd, ex_rs_a, ex_rs_b, id_rs_a, id_rs_b;
  logic       id_rs_b_used;
  logic       mem_reg_write_enable, mem_mem_write_enable, mem_mem_to_reg_select;
  logic [3:0] mem_rd;
  logic       wb_reg_write_enable, wb_mem_to_reg_select;
  logic [3:0] wb_rd;
  logic [1:0] fwd_a_select, fwd_b_select;
  logic       load_use_stall;

  typedef struct packed {
    logic       mrwe, mmwe, mm2r;
    logic [3:0] mrd;
    logic       wrwe, wm2r;
    logic [3:0] wrd;
    logic [1:0] fa, fb;
    logic       st;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ex_wb_ctrl_pipe #(.REG_ADDR_W(4), .PC_REG(15)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush_ex(flush_ex),
    .ex_reg_write_enable(ex_reg_write_enable),
    .ex_mem_write_enable(ex_mem_write_enable),
    .ex_mem_to_reg_select(ex_mem_to_reg_select),
    .ex_rd(ex_rd), .ex_rs_a(ex_rs_a), .ex_rs_b(ex_rs_b),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_rs_b_used(id_rs_b_used),
    .mem_reg_write_enable(mem_reg_write_enable),
    .mem_mem_write_enable(mem_mem_write_enable),
    .mem_mem_to_reg_select(mem_mem_to_reg_select),
    .mem_rd(mem_rd),
    .wb_reg_write_enable(wb_reg_write_enable),
    .wb_mem_to_reg_select(wb_mem_to_reg_select),
    .wb_rd(wb_rd),
    .fwd_a_select(fwd_a_select), .fwd_b_select(fwd_b_select),
    .load_use_stall(load_use_stall)
  );

  task automatic cmp(input string name, input int vec, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL v%0d %s: got %h expected %h", vec, name, act, exp);
    end
  endtask

  int vec_no = 0;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("mem_reg_write_enable",  vec_no, 4'(mem_reg_write_enable),  4'(e.mrwe));
      cmp("mem_mem_write_enable",  vec_no, 4'(mem_mem_write_enable),  4'(e.mmwe));
      cmp("mem_mem_to_reg_select", vec_no, 4'(mem_mem_to_reg_select), 4'(e.mm2r));
      cmp("mem_rd",                vec_no, mem_rd,                    e.mrd);
      cmp("wb_reg_write_enable",   vec_no, 4'(wb_reg_write_enable),   4'(e.wrwe));
      cmp("wb_mem_to_reg_select",  vec_no, 4'(wb_mem_to_reg_select),  4'(e.wm2r));
      cmp("wb_rd",                 vec_no, wb_rd,                     e.wrd);
      cmp("fwd_a_select",          vec_no, 4'(fwd_a_select),          4'(e.fa));
      cmp("fwd_b_select",          vec_no, 4'(fwd_b_select),          4'(e.fb));
      cmp("load_use_stall",        vec_no, 4'(load_use_stall),        4'(e.st));
      vec_no++;
    end
  end

  // Inputs change 1 time unit after posedge; the monitor samples at the next negedge.
  task automatic drv(input logic rst, input logic hld, input logic fl,
                     input logic rwe, input logic mwe, input logic m2r,
                     input logic [3:0] rd, input logic [3:0] rsa, input logic [3:0] rsb,
                     input logic [3:0] ida, input logic [3:0] idb, input logic idbu);
    @(posedge clk);
    #1;
    reset = rst; hold = hld; flush_ex = fl;
    ex_reg_write_enable = rwe; ex_mem_write_enable = mwe; ex_mem_to_reg_select = m2r;
    ex_rd = rd; ex_rs_a = rsa; ex_rs_b = rsb;
    id_rs_a = ida; id_rs_b = idb; id_rs_b_used = idbu;
  endtask

  task automatic ex(input logic mrwe, input logic mmwe, input logic mm2r,
                    input logic [3:0] mrd, input logic wrwe, input logic wm2r,
                    input logic [3:0] wrd, input logic [1:0] fa, input logic [1:0] fb,
                    input logic st);
    exp_t e;
    e = '{mrwe: mrwe, mmwe: mmwe, mm2r: mm2r, mrd: mrd, wrwe: wrwe, wm2r: wm2r,
          wrd: wrd, fa: fa, fb: fb, st: st};
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; flush_ex = 1'b0;
    ex_reg_write_enable = 1'b0; ex_mem_write_enable = 1'b0; ex_mem_to_reg_select = 1'b0;
    ex_rd = '0; ex_rs_a = '0; ex_rs_b = '0; id_rs_a = '0; id_rs_b = '0; id_rs_b_used = 1'b0;

    //   rst hld fl rwe mwe m2r rd  rsa rsb ida idb idbu
    // reset with nonzero inputs (first cycle state unknown, not checked)
    drv(1,0,0, 1,1,1, 4'd2, 4'd0, 4'd0, 4'd2, 4'd0, 0);
    drv(1,0,0, 1,1,1, 4'd2, 4'd0, 4'd0, 4'd2, 4'd0, 0); ex(0,0,0,4'd0, 0,0,4'd0, 2'b00,2'b00, 0);
    // back-to-back ALU dependency
    drv(0,0,0, 1,0,0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 0); ex(0,0,0,4'd0, 0,0,4'd0, 2'b00,2'b00, 0);
    drv(0,0,0, 0,0,0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 0); ex(1,0,0,4'd3, 0,0,4'd0, 2'b10,2'b00, 0);
    drv(0,0,0, 0,0,0, 4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 0); ex(0,0,0,4'd0, 1,0,4'd3, 2'b00,2'b01, 0);
    // double hazard, then PC register
    drv(0,0,0, 1,0,0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 0); ex(0,0,0,4'd0, 0,0,4'd0, 2'b00,2'b00, 0);
    drv(0,0,0, 1,0,0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 0); ex(1,0,0,4'd5, 0,0,4'd0, 2'b00,2'b00, 0);
    drv(0,0,0, 1,0,0, 4'd15,4'd5, 4'd0, 4'd0, 4'd0, 0); ex(1,0,0,4'd5, 1,0,4'd5, 2'b10,2'b00, 0);
    drv(0,0,0, 1,0,0, 4'd15,4'd15,4'd5, 4'd0, 4'd0, 0); ex(1,0,0,4'd15,1,0,4'd5, 2'b00,2'b01, 0);
    drv(0,0,0, 0,0,0, 4'd0, 4'd15,4'd0, 4'd0, 4'd0, 0); ex(1,0,0,4'd15,1,0,4'd15,2'b00,2'b00, 0);
    // load-use: rs_b used, rs_b unused, flushed
    drv(0,0,0, 1,0,1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd2, 1); ex(0,0,0,4'd0, 1,0,4'd15,2'b00,2'b00, 1);
    drv(0,0,0, 1,0,1, 4'd2, 4'd0, 4'd0, 4'd7, 4'd2, 0); ex(1,0,1,4'd2, 0,0,4'd0, 2'b00,2'b00, 0);
    drv(0,0,1, 1,0,1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd2, 1); ex(1,0,1,4'd2, 1,1,4'd2, 2'b00,2'b00, 0);
    // load forwarding timing
    drv(0,0,0, 1,0,1, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 0); ex(0,0,0,4'd0, 1,1,4'd2, 2'b00,2'b00, 0);
    drv(0,0,0, 0,0,0, 4'd0, 4'd4, 4'd0, 4'd0, 4'd0, 0); ex(1,0,1,4'd4, 0,0,4'd0, 2'b00,2'b00, 0);
    drv(0,0,0, 0,0,0, 4'd0, 4'd4, 4'd0, 4'd0, 4'd0, 0); ex(0,0,0,4'd0, 1,1,4'd4, 2'b01,2'b00, 0);
    // load to PC never stalls; store never stalls or forwards
    drv(0,0,0, 1,0,1, 4'd15,4'd0, 4'd0, 4'd15,4'd15,1); ex(0,0,0,4'd0, 0,0,4'd0, 2'b00,2'b00, 0);
    drv(0,0,0, 0,1,0, 4'd6, 4'd0, 4'd0, 4'd6, 4'd0, 0); ex(1,0,1,4'd15,0,0,4'd0, 2'b00,2'b00, 0);
    drv(0,0,0, 0,0,0, 4'd0, 4'd6, 4'd15,4'd0, 4'd0, 0); ex(0,1,0,4'd6, 1,1,4'd15,2'b00,2'b00, 0);
    // hold for 3 cycles (stall from EX still visible; flush ignored), then flush a store
    drv(0,0,0, 1,0,0, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 0); ex(0,0,0,4'd0, 0,0,4'd6, 2'b00,2'b00, 0);
    drv(0,1,0, 1,0,1, 4'd10,4'd9, 4'd0, 4'd10,4'd0, 0); ex(1,0,0,4'd9, 0,0,4'd0, 2'b10,2'b00, 1);
    drv(0,1,1, 1,0,1, 4'd10,4'd9, 4'd0, 4'd10,4'd0, 0); ex(1,0,0,4'd9, 0,0,4'd0, 2'b10,2'b00, 0);
    drv(0,1,0, 0,1,0, 4'd11,4'd0, 4'd0, 4'd0, 4'd0, 0); ex(1,0,0,4'd9, 0,0,4'd0, 2'b00,2'b00, 0);
    drv(0,0,1, 0,1,0, 4'd11,4'd0, 4'd0, 4'd0, 4'd0, 0); ex(1,0,0,4'd9, 0,0,4'd0, 2'b00,2'b00, 0);
    drv(0,0,0, 0,0,0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 0); ex(0,0,0,4'd0, 1,0,4'd9, 2'b00,2'b00, 0);
    // reset mid-stream
    drv(0,0,0, 1,0,0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 0); ex(0,0,0,4'd0, 0,0,4'd0, 2'b00,2'b00, 0);
    drv(0,0,0, 1,1,0, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 0); ex(1,0,0,4'd7, 0,0,4'd0, 2'b00,2'b00, 0);
    drv(1,0,0, 1,0,1, 4'd1, 4'd8, 4'd0, 4'd1, 4'd0, 0); ex(1,1,0,4'd8, 1,0,4'd7, 2'b10,2'b00, 0);
    drv(0,0,0, 0,0,0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 0); ex(0,0,0,4'd0, 0,0,4'd0, 2'b00,2'b00, 0);

    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
